// File: rtl/search_count_engine.sv
// Two-algorithm engine: popcount of A (mode 0) or binary search of a sorted sync-read memory for A (mode 1).
// Optional busy-cycle counter output 'cycles' is enabled by defining ENGINE_CYCLE_CNT_EN.
module search_count_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] A,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] loc,
    output logic              found,
    output logic              busy,
    output logic              done
`ifdef ENGINE_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CNT,
        ADDR,
        WAIT,
        CMP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              arm_q, arm_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] loc_q, loc_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] mid;
    logic              startAccept;

    // arm_q marks an edge where start was sampled (in IDLE) or released (in DONE); the FSM acts one edge later.
    assign startAccept = (state_q == IDLE) && !arm_q && start;
    assign mid         = ADDR_W'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            mode_q     <= 1'b0;
            shreg_q    <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            mem_addr_q <= '0;
            count_q    <= '0;
            loc_q      <= '0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            mode_q     <= mode_d;
            shreg_q    <= shreg_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            loc_q      <= loc_d;
            found_q    <= found_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q;
        mode_d     = mode_q;
        shreg_d    = shreg_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        mem_addr_d = mem_addr_q;
        count_d    = count_q;
        loc_d      = loc_q;
        found_d    = found_q;
        case (state_q)
            IDLE: begin
                if (arm_q) begin
                    arm_d   = 1'b0;
                    lo_d    = '0;
                    hi_d    = '1;
                    state_d = mode_q ? ADDR : CNT;
                end else if (startAccept) begin
                    arm_d   = 1'b1;
                    shreg_d = A;
                    mode_d  = mode;
                    count_d = '0;
                    loc_d   = '0;
                    found_d = 1'b0;
                end
            end
            CNT: begin
                if (shreg_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(shreg_q[0]);
                    shreg_d = shreg_q >> 1;
                end
            end
            ADDR: begin
                mem_addr_d = mid;
                state_d    = WAIT;
            end
            WAIT: begin
                state_d = CMP;
            end
            CMP: begin
                // Bounds checks before moving lo/hi keep them inside the address range.
                if (mem_rdata == shreg_q) begin
                    found_d = 1'b1;
                    loc_d   = mem_addr_q;
                    state_d = DONE;
                end else if (mem_rdata < shreg_q) begin
                    if (mem_addr_q == hi_q) begin
                        loc_d   = mem_addr_q;
                        state_d = DONE;
                    end else begin
                        lo_d    = mem_addr_q + ADDR_W'(1);
                        state_d = ADDR;
                    end
                end else begin
                    if (mem_addr_q == lo_q) begin
                        loc_d   = mem_addr_q;
                        state_d = DONE;
                    end else begin
                        hi_d    = mem_addr_q - ADDR_W'(1);
                        state_d = ADDR;
                    end
                end
            end
            DONE: begin
                if (arm_q) begin
                    arm_d   = 1'b0;
                    state_d = IDLE;
                end else if (!start) begin
                    arm_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                arm_d   = 1'b0;
            end
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign count    = count_q;
    assign loc      = loc_q;
    assign found    = found_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);

`ifdef ENGINE_CYCLE_CNT_EN
    logic [15:0] cycles_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cycles_q <= '0;
        end else if (startAccept) begin
            cycles_q <= '0;
        end else if (busy && (cycles_q != 16'hFFFF)) begin
            cycles_q <= cycles_q + 16'd1;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_search_count_engine.sv
// Scoreboard bench for search_count_engine: stimulus queues expected results, a monitor checks each done.
module tb_search_count_engine;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       modeIn;
    logic [7:0] aIn;
    logic [4:0] memAddr;
    logic [7:0] memRdata;
    logic [3:0] count;
    logic [4:0] loc;
    logic       found;
    logic       busy;
    logic       done;
`ifdef ENGINE_CYCLE_CNT_EN
    logic [15:0] cycles;
`endif

    typedef struct {
        logic [3:0] cnt;
        logic [4:0] loc;
        logic       found;
        int         doneEdge;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    logic [7:0] mem [32];
    int         checks = 0;
    int         errors = 0;
    int         edgeCnt = 0;
    logic       prevDone = 1'b0;

    search_count_engine dut (
        .clk      (clk),
        .Reset    (resetN),
        .start    (start),
        .mode     (modeIn),
        .A        (aIn),
        .mem_addr (memAddr),
        .mem_rdata(memRdata),
        .count    (count),
        .loc      (loc),
        .found    (found),
        .busy     (busy),
        .done     (done)
`ifdef ENGINE_CYCLE_CNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    // Synchronous-read sorted memory: mem[i] = 2*i.
    always @(posedge clk) memRdata <= mem[memAddr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    // Monitor: every rising done pops one expected result.
    always @(negedge clk) begin
        if (resetN && done && !prevDone) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("count", 32'(count), 32'(monE.cnt));
                checkOutput("loc", 32'(loc), 32'(monE.loc));
                checkOutput("found", 32'(found), 32'(monE.found));
                checkOutput("done_edge", edgeCnt, monE.doneEdge);
                checkOutput("busy_in_done", 32'(busy), 0);
            end
        end
        prevDone = done;
    end

    task automatic applyStimulus(input logic m, input logic [7:0] a, input int lat,
                                 input logic [3:0] eCnt, input logic [4:0] eLoc, input logic eFound,
                                 input int holdCycles, input bit disturb);
        exp_t e;
        int   k;
        bit   seen;
        @(negedge clk);
        modeIn = m;
        aIn    = a;
        start  = 1'b1;
        k      = edgeCnt + 1;
        e.cnt = eCnt; e.loc = eLoc; e.found = eFound; e.doneEdge = k + lat;
        expQ.push_back(e);
        @(negedge clk);
        checkOutput("busy_after_k", 32'(busy), 0);
        @(negedge clk);
        checkOutput("busy_after_k1", 32'(busy), 1);
        if (disturb) begin
            @(negedge clk);
            aIn    = ~a;
            modeIn = ~m;
            start  = 1'b0;
            @(negedge clk);
            start  = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checkOutput("done_timeout", 0, 1);
            if (expQ.size() > 0) void'(expQ.pop_front());
        end
        repeat (holdCycles) @(negedge clk);
        checkOutput("done_held_start", 32'(done), 1);
        start = 1'b0;
        @(negedge clk);
        checkOutput("done_release_edge", 32'(done), 1);
        @(negedge clk);
        checkOutput("done_low_idle", 32'(done), 0);
        checkOutput("count_held_idle", 32'(count), 32'(eCnt));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
        resetN = 1'b0;
        start  = 1'b0;
        modeIn = 1'b0;
        aIn    = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_loc", 32'(loc), 0);
        checkOutput("rst_found", 32'(found), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_mem_addr", 32'(memAddr), 0);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(1'b0, 8'hB5, 10, 4'd5, 5'd0, 1'b0, 3, 1'b0);
        applyStimulus(1'b0, 8'h00, 2, 4'd0, 5'd0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 8'h80, 10, 4'd1, 5'd0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd20, 16, 4'd0, 5'd10, 1'b1, 1, 1'b0);
        applyStimulus(1'b1, 8'd62, 19, 4'd0, 5'd31, 1'b1, 0, 1'b0);
        applyStimulus(1'b1, 8'd21, 16, 4'd0, 5'd10, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 8'd0, 16, 4'd0, 5'd0, 1'b1, 0, 1'b0);

        // Abort a search with reset; nothing is queued for it.
        @(negedge clk);
        modeIn = 1'b1;
        aIn    = 8'd20;
        start  = 1'b1;
        repeat (7) @(negedge clk);
        checkOutput("mid_search_busy", 32'(busy), 1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(count), 0);
        checkOutput("async_rst_loc", 32'(loc), 0);
        checkOutput("async_rst_found", 32'(found), 0);
        checkOutput("async_rst_busy", 32'(busy), 0);
        checkOutput("async_rst_done", 32'(done), 0);
        checkOutput("async_rst_mem_addr", 32'(memAddr), 0);
        start = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 8'h0F, 6, 4'd4, 5'd0, 1'b0, 0, 1'b0);

        // A/mode toggled and start pulsed while counting must not disturb the latched operation.
        applyStimulus(1'b0, 8'hB5, 10, 4'd5, 5'd0, 1'b0, 0, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
